score_tracker: RTL
==================

Name: score_tracker

Overview:
- Parametrised successor to the single-pipe score counter; tracks score in BCD and keeps a session high score.
- Counts each pipe exactly once when it crosses the bird column, across PIPE_CNT independent pipe channels.
- Adds a game-state FSM, frame-tick qualified sampling, saturation and a new-high flag.
- Sits between the game-logic/collision block and the seven-segment/HUD renderer.

Parameters:
- DIGITS, 3, number of BCD digits in score and high score.
- PIPE_CNT, 2, number of pipe x-position channels monitored.
- X_W, 10, width of each pipe x coordinate.
- BIRD_X, 10'd160, bird column; a pipe passes when its x drops below this value.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-Clk pulse per video frame; pipe positions are sampled only on this pulse
- game_start  in  1  one-Clk pulse requesting a new game
- bird_killed  in  1  level, collision detected
- pipe_x  in  PIPE_CNT*X_W  packed pipe x positions, channel i at [i*X_W +: X_W]
- score_bcd  out  4*DIGITS  current score, digit 0 = LSD at [3:0]
- high_bcd  out  4*DIGITS  highest score since reset
- new_high  out  1  sticky: last finished game set a new high
- score_inc  out  1  one-Clk pulse on any cycle the score increases
- state  out  2  00 IDLE, 01 PLAYING, 10 DEAD

Behaviour:
- Reset (async assert, sync release): state=IDLE, score_bcd=0, high_bcd=0, new_high=0, score_inc=0, all prev_x=0.
- IDLE: score_bcd holds the last value. game_start -> PLAYING.
- Entering PLAYING (the game_start cycle):
  - score_bcd<=0 and new_high<=0.
  - prev_x[i]<=pipe_x[i] for every channel, so no spurious pass is counted.
- PLAYING, on frame_tick:
  - pass[i] = (pipe_x[i] < BIRD_X) && (prev_x[i] >= BIRD_X).
  - Then prev_x[i]<=pipe_x[i] for every channel.
  - Without frame_tick, prev_x and score hold.
- Wrap-around: a pipe respawning at the right edge has prev<BIRD_X and cur>=BIRD_X, so no pass is counted.
- Increment rule:
  - k = popcount(pass), 0..PIPE_CNT.
  - Score increases by k in one Clk, using decimal carry across digits.
  - Result is registered: score_bcd updates on the edge ending the frame_tick cycle.
  - score_inc=1 on that same edge when k>0.
- Saturation: the score never exceeds 10^DIGITS-1 (all 9s). Increments beyond it clamp; score_inc still pulses when k>0.
- bird_killed in PLAYING -> DEAD next edge.
  - Kill wins over a same-cycle pass: no increment and no score_inc.
- Entering DEAD, on the same edge:
  - If score_bcd > high_bcd (unsigned BCD compare), high_bcd<=score_bcd and new_high<=1.
  - Equal scores do not update.
- DEAD: score and high hold; bird_killed is ignored. game_start -> PLAYING with the entry actions above.
- game_start while PLAYING is ignored.
- Reset mid-game: all state cleared immediately, including high_bcd.
- Illegal state 11 -> IDLE.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then game_start, one pipe stepping 200->150 on frame_tick (BIRD_X=160) -> score_bcd=001 and score_inc pulses once. Holding x=150 for more ticks leaves the score at 001.
- Both channels cross on the same frame_tick -> score increases by 2 in one Clk. Score 009 -> 011 checks the decimal carry.
- Pipe wraps 5->630 then later descends 170->155 -> exactly one increment, from the descent only.
- Preload the score to 998 via passes, then a two-pipe simultaneous pass -> score_bcd=999 (saturated) and score_inc=1.
- Score 012 with high 007, bird_killed -> state DEAD, high_bcd=012, new_high=1. Next game reaching 005 then killed -> high stays 012, new_high=0.
- Pass and bird_killed in the same cycle -> no increment and state DEAD. Reset_n low mid-PLAYING -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/score_tracker.sv
// score_tracker: BCD score and session high-score keeper for multi-channel pipe passing.
module score_tracker #(
    parameter int DIGITS = 3,
    parameter int PIPE_CNT = 2,
    parameter int X_W = 10,
    parameter logic [X_W-1:0] BIRD_X = 10'd160
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_tick,
    input  logic                      game_start,
    input  logic                      bird_killed,
    input  logic [PIPE_CNT*X_W-1:0]   pipe_x,
    output logic [4*DIGITS-1:0]       score_bcd,
    output logic [4*DIGITS-1:0]       high_bcd,
    output logic                      new_high,
    output logic                      score_inc,
    output logic [1:0]                state
);
    localparam int KW = $clog2(PIPE_CNT + 1);
    localparam int SW = $clog2(PIPE_CNT + 10);
    localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'd9}};

    typedef enum logic [1:0] {IDLE = 2'b00, PLAYING = 2'b01, DEAD = 2'b10} state_t;

    state_t                  state_q, state_d;
    logic [4*DIGITS-1:0]     score_q, score_d, high_q, high_d, sum_bcd;
    logic                    new_high_q, new_high_d, inc_q, inc_d;
    logic [PIPE_CNT*X_W-1:0] prev_q, prev_d;
    logic [KW-1:0]           k, carry;
    logic [SW-1:0]           sum;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        inc_d      = 1'b0;
        prev_d     = prev_q;
        sum        = '0;
        sum_bcd    = '0;
        k          = '0;
        for (int i = 0; i < PIPE_CNT; i++)
            k = k + KW'((pipe_x[i*X_W +: X_W] < BIRD_X) && (prev_q[i*X_W +: X_W] >= BIRD_X));
        // ripple the pass count through the digits as a decimal carry
        carry = k;
        for (int d = 0; d < DIGITS; d++) begin
            sum = SW'(score_q[d*4 +: 4]) + SW'(carry);
            sum_bcd[d*4 +: 4] = 4'(sum % SW'(10));
            carry = KW'(sum / SW'(10));
        end
        case (state_q)
            IDLE, DEAD: begin
                if (game_start) begin
                    state_d    = PLAYING;
                    score_d    = '0;
                    new_high_d = 1'b0;
                    prev_d     = pipe_x;
                end
            end
            PLAYING: begin
                if (bird_killed) begin
                    state_d = DEAD;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end
                end else if (frame_tick) begin
                    prev_d  = pipe_x;
                    score_d = (carry != '0) ? ALL9 : sum_bcd;
                    inc_d   = (k != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            inc_q      <= 1'b0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            inc_q      <= inc_d;
            prev_q     <= prev_d;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign new_high  = new_high_q;
    assign score_inc = inc_q;
    assign state     = state_q;
endmodule
